// File: rtl/dispatch_buffer_pkg.sv
// Shared widths, uop field layout and branch-kill helper for the dispatch buffer.
package dispatch_buffer_pkg;

    localparam int unsigned DEF_WIDTH_REG = 5;
    localparam int unsigned DEF_WIDTH_TAG = 5;
    localparam int unsigned DEF_WIDTH_BRM = 3;
    localparam int unsigned DEF_WIDTH_PRY = 2;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_NSLOT     = 8;

    localparam int unsigned WIDTH_OPC     = 7;

    // Low-order flag bits of every uop, then the priority field.
    localparam int unsigned BIT_P1        = 0;
    localparam int unsigned BIT_P2        = 1;
    localparam int unsigned BIT_VAL       = 2;
    localparam int unsigned OFF_PRY       = 3;

    // Widest branch mask the kill helper accepts.
    localparam int unsigned MAX_WIDTH_BRM = 5;
    localparam int unsigned KILL_W        = 32;

    // uop layout at default widths, MSB first.
    typedef struct packed {
        logic [WIDTH_OPC-1:0]     opcode;
        logic [DEF_WIDTH_BRM-1:0] br_mask;
        logic [DEF_WIDTH_TAG-1:0] tag;
        logic [DEF_WIDTH_REG-1:0] rdst;
        logic [DEF_WIDTH_REG-1:0] rs2;
        logic [DEF_WIDTH_REG-1:0] rs1;
        logic [DEF_WIDTH_PRY-1:0] pry;
        logic                     val;
        logic                     p2;
        logic                     p1;
    } uop_t;

    // A uop is killed when the kill vector bit selected by its branch mask is set.
    function automatic logic killf(input logic [KILL_W-1:0]        brkill,
                                   input logic [MAX_WIDTH_BRM-1:0] br_mask);
        return brkill[br_mask];
    endfunction

endpackage

// File: rtl/dispatch_buffer_pick_free.sv
// Lowest-index free issue slot as a one-hot grant, plus an any-free flag.
module dispatch_buffer_pick_free #(
    parameter int unsigned NSLOT = 8
) (
    input  logic [NSLOT-1:0] busy,
    output logic [NSLOT-1:0] grant_c,
    output logic             any_free_c
);

    logic [NSLOT-1:0] free;

    // Isolate the lowest set bit of the free vector.
    always_comb begin
        free       = ~busy;
        grant_c    = free & (~free + NSLOT'(1));
        any_free_c = |free;
    end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular uop buffer between rename and the issue slots, with wakeup snooping and branch kill.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH_REG = DEF_WIDTH_REG,
    parameter int unsigned WIDTH_TAG = DEF_WIDTH_TAG,
    parameter int unsigned WIDTH_BRM = DEF_WIDTH_BRM,
    parameter int unsigned WIDTH_PRY = DEF_WIDTH_PRY,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NSLOT     = DEF_NSLOT,
    localparam int unsigned WIDTH_I  = WIDTH_OPC + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + WIDTH_PRY + 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [WIDTH_I-1:0]          i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [WIDTH_I-1:0]          o_data,
    output logic [NSLOT-1:0]            o_en,
    input  logic [NSLOT-1:0]            i_slot_busy,
    input  logic [4*WIDTH_REG-1:0]      i_WDest4x,
    input  logic [(1 << WIDTH_BRM)-1:0] i_brkill
);

    localparam int unsigned OFF_RS1 = OFF_PRY + WIDTH_PRY;
    localparam int unsigned OFF_RS2 = OFF_RS1 + WIDTH_REG;
    localparam int unsigned OFF_BRM = OFF_RS2 + 2*WIDTH_REG + WIDTH_TAG;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic [WIDTH_I-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               push_c;
    logic               pop_c;
    logic               head_kill_c;
    logic [WIDTH_I-1:0] head_uop_c;
    logic [CNT_W-1:0]   count_nxt_c;
    logic [NSLOT-1:0]   grant_c;
    logic               any_free_c;

    // True when any of the four wakeup lanes names register r.
    function automatic logic wake(input logic [WIDTH_REG-1:0]   r,
                                  input logic [4*WIDTH_REG-1:0] lanes);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hit = hit | (lanes[k*WIDTH_REG +: WIDTH_REG] == r);
        end
        return hit;
    endfunction

    // Fold this cycle's wakeups into a uop's ready bits.
    function automatic logic [WIDTH_I-1:0] snoop(input logic [WIDTH_I-1:0]     u,
                                                 input logic [4*WIDTH_REG-1:0] lanes);
        logic [WIDTH_I-1:0] r;
        r         = u;
        r[BIT_P1] = u[BIT_P1] | wake(u[OFF_RS1 +: WIDTH_REG], lanes);
        r[BIT_P2] = u[BIT_P2] | wake(u[OFF_RS2 +: WIDTH_REG], lanes);
        return r;
    endfunction

    function automatic logic killed(input logic [WIDTH_I-1:0]          u,
                                    input logic [(1 << WIDTH_BRM)-1:0] bk);
        return killf(KILL_W'(bk), MAX_WIDTH_BRM'(u[OFF_BRM +: WIDTH_BRM]));
    endfunction

    dispatch_buffer_pick_free #(
        .NSLOT      (NSLOT)
    ) u_pick_free (
        .busy       (i_slot_busy),
        .grant_c    (grant_c),
        .any_free_c (any_free_c)
    );

    // Head dispatch/discard decision and the zero-latency issue payload.
    always_comb begin
        head_uop_c  = mem[head];
        head_kill_c = killed(head_uop_c, i_brkill);
        push_c      = i_valid & o_ready;
        pop_c       = 1'b0;
        o_en        = '0;
        if (count != '0) begin
            if (!vld[head]) begin
                pop_c = 1'b1;
            end else if (!head_kill_c && any_free_c) begin
                pop_c = 1'b1;
                o_en  = grant_c;
            end
        end
        count_nxt_c     = count + CNT_W'(push_c) - CNT_W'(pop_c);
        o_data          = snoop(head_uop_c, i_WDest4x);
        o_data[BIT_VAL] = 1'b1;
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            o_ready <= 1'b1;
        end else begin
            if (push_c) tail <= tail + PTR_W'(1);
            if (pop_c)  head <= head + PTR_W'(1);
            count   <= count_nxt_c;
            o_ready <= (count_nxt_c < CNT_W'(DEPTH));
        end
    end

    // Per-entry valid bits: set on push unless killed, cleared on pop or kill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_c && tail == PTR_W'(i)) begin
                    vld[i] <= !killed(i_data, i_brkill);
                end else if (pop_c && head == PTR_W'(i)) begin
                    vld[i] <= 1'b0;
                end else if (killed(mem[i], i_brkill)) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage (not reset): write on push, otherwise accumulate wakeups.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_c && tail == PTR_W'(i)) begin
                mem[i] <= snoop(i_data, i_WDest4x);
            end else begin
                mem[i] <= snoop(mem[i], i_WDest4x);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: directed table, corner sequences, random vs. queue model.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NSLOT = 8;
    localparam int unsigned WI    = $bits(uop_t);

    logic             clk;
    logic             rst_n;
    logic [WI-1:0]    i_data;
    logic             i_valid;
    logic             o_ready;
    logic [WI-1:0]    o_data;
    logic [NSLOT-1:0] o_en;
    logic [NSLOT-1:0] i_slot_busy;
    logic [19:0]      i_WDest4x;
    logic [7:0]       i_brkill;

    int n_chk  = 0;
    int n_fail = 0;

    dispatch_buffer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_en        (o_en),
        .i_slot_busy (i_slot_busy),
        .i_WDest4x   (i_WDest4x),
        .i_brkill    (i_brkill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { uop_t u; bit v; } ent_t;
    ent_t q[$];

    typedef struct {
        bit         valid;
        uop_t       data;
        logic [7:0] busy;
        logic [19:0] wd;
        logic [7:0] bk;
        logic [7:0] en;
        bit         rdy;
        uop_t       xd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit wk(input logic [4:0] r, input logic [19:0] w);
        bit hit;
        hit = 0;
        for (int k = 0; k < 4; k++) if (w[k*5 +: 5] == r) hit = 1;
        return hit;
    endfunction

    function automatic uop_t mk(input logic [6:0] opc, input logic [2:0] brm, input logic [4:0] tag,
                                input logic [4:0] rdst, input logic [4:0] rs2, input logic [4:0] rs1,
                                input logic [1:0] pry);
        uop_t u;
        u.opcode = opc; u.br_mask = brm; u.tag = tag; u.rdst = rdst;
        u.rs2 = rs2; u.rs1 = rs1; u.pry = pry; u.val = 0; u.p2 = 0; u.p1 = 0;
        return u;
    endfunction

    function automatic uop_t ex(input uop_t u, input bit p1, input bit p2);
        uop_t r;
        r = u; r.val = 1; r.p1 = p1; r.p2 = p2;
        return r;
    endfunction

    // One cycle: drive, check against the queue model, then advance the model at the edge.
    task automatic step(input bit valid, input uop_t d, input logic [7:0] busy, input logic [19:0] wd,
                        input logic [7:0] bk, output logic [7:0] a_en, output logic a_rdy,
                        output uop_t a_data);
        bit         e_rdy;
        bit         pop;
        bit         found;
        logic [7:0] e_en;
        uop_t       e_data;
        ent_t       t;
        @(negedge clk);
        i_valid = valid; i_data = d; i_slot_busy = busy; i_WDest4x = wd; i_brkill = bk;
        #1;
        e_rdy = (q.size() < DEPTH);
        e_en = '0; pop = 0; e_data = '0; found = 0;
        if (q.size() > 0) begin
            if (!q[0].v) begin
                pop = 1;
            end else if (!bk[q[0].u.br_mask] && busy != 8'hFF) begin
                for (int s = 0; s < NSLOT; s++) begin
                    if (!busy[s] && !found) begin
                        e_en = 8'(1) << s;
                        found = 1;
                    end
                end
                pop = 1;
                e_data = ex(q[0].u, q[0].u.p1 | wk(q[0].u.rs1, wd), q[0].u.p2 | wk(q[0].u.rs2, wd));
            end
        end
        a_en = o_en; a_rdy = o_ready; a_data = uop_t'(o_data);
        chk("model_ready", 64'(a_rdy), 64'(e_rdy));
        chk("model_en", 64'(a_en), 64'(e_en));
        if (e_en != 0) chk("model_data", 64'(a_data), 64'(e_data));
        @(posedge clk);
        for (int i = 0; i < q.size(); i++) begin
            t = q[i];
            if (bk[t.u.br_mask]) t.v = 0;
            t.u.p1 = t.u.p1 | wk(t.u.rs1, wd);
            t.u.p2 = t.u.p2 | wk(t.u.rs2, wd);
            q[i] = t;
        end
        if (pop) void'(q.pop_front());
        if (valid && e_rdy) begin
            t.u = d;
            t.u.p1 = d.p1 | wk(d.rs1, wd);
            t.u.p2 = d.p2 | wk(d.rs2, wd);
            t.v = !bk[d.br_mask];
            q.push_back(t);
        end
    endtask

    // Asynchronous reset with free slots offered, so any stale head would show on o_en.
    task automatic do_reset();
        @(negedge clk);
        i_valid = 0; i_slot_busy = '0; i_brkill = '0; i_WDest4x = '0;
        rst_n = 0;
        #1;
        chk("rst_en", 64'(o_en), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(1));
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_hold_en", 64'(o_en), 64'(0));
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_en", 64'(o_en), 64'(0));
        chk("rel_ready", 64'(o_ready), 64'(1));
    endtask

    function automatic uop_t rnd_uop();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return uop_t'(r[WI-1:0]);
    endfunction

    initial begin
        vec_t       tbl[19];
        uop_t       ua, ub, uc, ud, ue, uf, ug, uh, z;
        logic [7:0] a_en;
        logic       a_rdy;
        uop_t       a_data;
        logic [7:0] bk;
        logic [7:0] busy;

        rst_n = 0; i_valid = 0; i_data = '0; i_slot_busy = '0; i_WDest4x = '0; i_brkill = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_en", 64'(o_en), 64'(0));
        chk("init_ready", 64'(o_ready), 64'(1));
        @(negedge clk);
        rst_n = 1;

        z  = '0;
        ua = mk(7'h11, 3'd1, 5'd1, 5'd20, 5'd9,  5'd7,  2'd1);
        ub = mk(7'h22, 3'd3, 5'd2, 5'd21, 5'd14, 5'd15, 2'd2);
        uc = mk(7'h33, 3'd2, 5'd3, 5'd22, 5'd16, 5'd17, 2'd3);
        ud = mk(7'h44, 3'd4, 5'd4, 5'd23, 5'd18, 5'd19, 2'd0);
        ue = mk(7'h55, 3'd0, 5'd5, 5'd24, 5'd25, 5'd26, 2'd1);
        uf = mk(7'h66, 3'd5, 5'd6, 5'd25, 5'd27, 5'd28, 2'd2);
        ug = mk(7'h77, 3'd6, 5'd7, 5'd26, 5'd11, 5'd29, 2'd3);
        uh = mk(7'h08, 3'd7, 5'd8, 5'd27, 5'd13, 5'd30, 2'd0);

        //          valid data busy          wdest lanes {3,2,1,0}             kill          en            rdy xd
        tbl[0]  = '{1, ua, 8'hFF,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[1]  = '{1, ub, 8'hFF,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[2]  = '{1, uc, 8'hFF,        {5'd0, 5'd0, 5'd0, 5'd9},  8'h00,        8'h00,        1, z};
        tbl[3]  = '{1, ud, 8'hFF,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[4]  = '{1, ue, 8'hFF,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        0, z};
        tbl[5]  = '{0, z,  8'b1101_1011, {5'd0, 5'd7, 5'd0, 5'd0},  8'h00,        8'b0000_0100, 0, ex(ua, 1, 1)};
        tbl[6]  = '{0, z,  8'hFF,        {5'd0, 5'd0, 5'd0, 5'd0},  8'b0000_1000, 8'h00,        1, z};
        tbl[7]  = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[8]  = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h01,        1, ex(uc, 0, 0)};
        tbl[9]  = '{0, z,  8'h01,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h02,        1, ex(ud, 0, 0)};
        tbl[10] = '{1, ue, 8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[11] = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h01,        1, ex(ue, 0, 0)};
        tbl[12] = '{1, uf, 8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'b0010_0000, 8'h00,        1, z};
        tbl[13] = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[14] = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};
        tbl[15] = '{1, ug, 8'h00,        {5'd11, 5'd0, 5'd0, 5'd0}, 8'h00,        8'h00,        1, z};
        tbl[16] = '{1, uh, 8'h00,        {5'd0, 5'd0, 5'd13, 5'd0}, 8'h00,        8'h01,        1, ex(ug, 0, 1)};
        tbl[17] = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h01,        1, ex(uh, 0, 1)};
        tbl[18] = '{0, z,  8'h00,        {5'd0, 5'd0, 5'd0, 5'd0},  8'h00,        8'h00,        1, z};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].valid, tbl[i].data, tbl[i].busy, tbl[i].wd, tbl[i].bk, a_en, a_rdy, a_data);
            chk($sformatf("tbl%0d_en", i), 64'(a_en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_ready", i), 64'(a_rdy), 64'(tbl[i].rdy));
            if (tbl[i].en != 0) chk($sformatf("tbl%0d_data", i), 64'(a_data), 64'(tbl[i].xd));
        end

        // Full buffer: pop with a concurrent push attempt, then pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, rnd_uop(), 8'hFF, 20'h0, 8'h00, a_en, a_rdy, a_data);
        step(1, rnd_uop(), 8'hFE, 20'h0, 8'h00, a_en, a_rdy, a_data);
        chk("full_pop_ready", 64'(a_rdy), 64'(0));
        chk("full_pop_en", 64'(a_en), 64'(8'h01));
        step(0, z, 8'hFF, 20'h0, 8'h00, a_en, a_rdy, a_data);
        chk("after_pop_ready", 64'(a_rdy), 64'(1));
        step(1, rnd_uop(), 8'hFF, 20'h0, 8'h00, a_en, a_rdy, a_data);
        for (int i = 0; i < 5; i++) step(0, z, 8'h00, 20'h0, 8'h00, a_en, a_rdy, a_data);

        // Randomized traffic checked against the queue model.
        for (int n = 0; n < 2000; n++) begin
            bk   = ($urandom_range(0, 7) == 0) ? (8'(1) << $urandom_range(0, 7)) : 8'h00;
            busy = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom());
            step(bit'($urandom_range(0, 1)), rnd_uop(), busy, 20'($urandom()), bk, a_en, a_rdy, a_data);
        end

        // Reset with three uops pending and free slots offered.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, rnd_uop(), 8'hFF, 20'h0, 8'h00, a_en, a_rdy, a_data);
        do_reset();
        step(0, z, 8'h00, 20'h0, 8'h00, a_en, a_rdy, a_data);
        chk("post_rst_en", 64'(a_en), 64'(0));
        chk("post_rst_ready", 64'(a_rdy), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
